fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the program counter for the single-issue core.
- Issues instruction-memory fetches through a request/acknowledge handshake and hands fetched instructions to decode through a valid/ready handshake.
- Stalls on control-flow opcodes (JAL 1101111, JALR 1100111, BRANCH 1100011) until the execute stage resolves them, then redirects the PC by a signed offset or advances it by 4.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
RES_TIMEOUT, 16, maximum cycles spent in RESOLVE before the block flags an error (range 1..255)

Ports:
CLK  input  1  clock; all state updates on the rising edge
RESET  input  1  asynchronous, active-low reset
EN  input  1  fetch enable
IMEM_REQ  output  1  fetch request
IMEM_ADDR  output  32  fetch address; always equals PC
IMEM_ACK  input  1  fetch complete; IMEM_RDATA valid in the same cycle
IMEM_RDATA  input  32  fetched instruction
INSTR  output  32  instruction to decode
INSTR_VALID  output  1  INSTR holds a valid instruction
INSTR_READY  input  1  decode accepts INSTR
PC_OUT  output  32  address of INSTR
RES_VALID  input  1  control-flow resolution strobe
RES_TAKEN  input  1  resolved instruction is taken
RES_OFFSET  input  32  signed byte offset applied to PC when taken
ERR  output  1  sticky fault flag

Behaviour:
- Reset (RESET low, asynchronous assert): state IDLE, PC=RESET_VEC, IMEM_REQ=0, INSTR=0, INSTR_VALID=0, PC_OUT=RESET_VEC, ERR=0, timeout counter=0. Deassertion is taken synchronously to CLK.
- Reset asserted mid-operation aborts any in-flight fetch or resolution with no further output activity. A late IMEM_ACK is ignored unless state is FETCH.
- IMEM_REQ is a registered output equal to (state==FETCH).
- IDLE: if EN=1, go to FETCH; otherwise remain.
- FETCH:
  - IMEM_REQ=1; IMEM_ADDR is held stable until IMEM_ACK.
  - On IMEM_ACK: INSTR<=IMEM_RDATA, PC_OUT<=PC, INSTR_VALID<=1; go to HOLD.
  - EN falling while in FETCH does not abort the fetch.
  - Fetch latency: at least 1 cycle from IMEM_REQ rising to INSTR_VALID rising (ACK in the first REQ cycle gives INSTR_VALID on the next edge).
- HOLD:
  - INSTR and INSTR_VALID are held until INSTR_READY=1 is sampled; the handshake completes in that cycle and INSTR_VALID<=0.
  - If INSTR[6:0] is a control-flow opcode: go to RESOLVE, PC unchanged, timeout counter cleared.
  - Otherwise: PC<=PC+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), then go to FETCH if EN=1, else IDLE.
- RESOLVE:
  - Wait for RES_VALID. The timeout counter increments each cycle RES_VALID is low.
  - RES_VALID & RES_TAKEN: target=PC+RES_OFFSET (32-bit wrap). If target[1:0]!=0: ERR<=1, go to IDLE, PC unchanged. Otherwise PC<=target.
  - RES_VALID & !RES_TAKEN: PC<=PC+4.
  - After a successful update, go to FETCH if EN=1, else IDLE.
  - If the counter reaches RES_TIMEOUT with no RES_VALID: ERR<=1, go to IDLE, PC unchanged.
- RES_VALID is ignored in every state except RESOLVE.
- ERR is sticky. While ERR=1 the block stays in IDLE regardless of EN. Only RESET clears it.
- Only one outstanding fetch at a time; no speculative fetch past a control-flow opcode.

Optional Feature:
FETCH_CTRL_PERF_EN
- Defined: adds outputs PERF_INSTR (32) and PERF_STALL (32), both reset to 0 and wrapping at 2^32.
  - PERF_INSTR increments on each INSTR_VALID & INSTR_READY handshake.
  - PERF_STALL increments on each cycle spent in RESOLVE or in FETCH without IMEM_ACK.
- Undefined: both ports remain in the interface, tied to 0, with no counter logic.

Test Plan:
- Reset with RESET_VEC=32'h100, EN=1, IMEM_ACK returned 1 cycle after each REQ, INSTR_READY=1, non-branch instructions (e.g. 32'h00000013) -> IMEM_ADDR sequence 0x100, 0x104, 0x108; PC_OUT matches each INSTR.
- Branch 32'h00000063 fetched at 0x200, RES_VALID=1, RES_TAKEN=1, RES_OFFSET=32'hFFFF_FFF0 three cycles later -> no IMEM_REQ while resolving; next IMEM_ADDR=0x1F0. Repeat with RES_TAKEN=0 -> next IMEM_ADDR=0x204.
- INSTR_READY held low for 5 cycles after INSTR_VALID -> INSTR stable, no new IMEM_REQ; next fetch starts only after the handshake.
- JAL at 0x300, RES_OFFSET=32'h6 taken -> ERR=1, block idles with EN=1, PC_OUT=0x300; RES_TIMEOUT=4 with RES_VALID never asserted -> ERR=1 after 4 RESOLVE cycles.
- PC at 32'hFFFF_FFFC, non-branch instruction -> next IMEM_ADDR=0x0.
- RESET pulsed low mid-FETCH with IMEM_ACK arriving during reset -> IMEM_REQ=0 and INSTR_VALID=0 immediately, no capture; fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer for the single-issue core.
//   Fetches one instruction at a time over a req/ack memory handshake and
//   presents it to decode over a valid/ready handshake. A control-flow opcode
//   (JAL, JALR, BRANCH) parks the block until execute resolves it, then the
//   PC is redirected by a signed offset or advanced by 4.
//
// Optional build macro: FETCH_CTRL_PERF_EN enables the PERF_INSTR/PERF_STALL
//   counters; without it both outputs are tied to zero.
//
// Ports:
//   CLK, RESET                      clock, async active-low reset
//   EN                              fetch enable
//   IMEM_REQ/ADDR/ACK/RDATA         instruction memory handshake
//   INSTR/INSTR_VALID/INSTR_READY   decode handshake
//   PC_OUT                          address of INSTR
//   RES_VALID/RES_TAKEN/RES_OFFSET  control-flow resolution from execute
//   ERR                             sticky fault (misaligned target or timeout)
//   PERF_INSTR/PERF_STALL           optional performance counters
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for EN; parked here permanently while ERR=1
// FETCH   | IMEM_REQ high, IMEM_ADDR=PC held until IMEM_ACK
// HOLD    | INSTR_VALID high until decode samples INSTR_READY
// RESOLVE | control-flow opcode issued, waiting for RES_VALID or timeout
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          RES_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    output logic [31:0] PC_OUT,
    input  logic        RES_VALID,
    input  logic        RES_TAKEN,
    input  logic [31:0] RES_OFFSET,
    output logic        ERR,
    output logic [31:0] PERF_INSTR,
    output logic [31:0] PERF_STALL
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_RESOLVE = 2'd3
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Timeout fires on the RES_TIMEOUT-th RESOLVE cycle without RES_VALID.
    localparam logic [7:0] TMO_LAST = 8'(RES_TIMEOUT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        imem_req;
    logic        instr_valid;
    logic        err;
    logic [7:0]  tmo_cnt;

    logic [31:0] res_target;
    logic        instr_is_cf;

    assign res_target  = pc + RES_OFFSET;
    assign instr_is_cf = (instr[6:0] == OP_JAL) || (instr[6:0] == OP_JALR) ||
                         (instr[6:0] == OP_BRANCH);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            pc          <= RESET_VEC;
            instr       <= '0;
            pc_out      <= RESET_VEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            err         <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (EN && !err) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // EN is deliberately not checked: a started fetch always completes.
                    if (IMEM_ACK) begin
                        instr       <= IMEM_RDATA;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (INSTR_READY) begin
                        instr_valid <= 1'b0;
                        if (instr_is_cf) begin
                            tmo_cnt <= '0;
                            state   <= S_RESOLVE;
                        end else begin
                            pc       <= pc + 32'd4;
                            imem_req <= EN;
                            state    <= EN ? S_FETCH : S_IDLE;
                        end
                    end
                end
                S_RESOLVE: begin
                    if (RES_VALID) begin
                        if (RES_TAKEN && (res_target[1:0] != 2'b00)) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            pc       <= RES_TAKEN ? res_target : pc + 32'd4;
                            imem_req <= EN;
                            state    <= EN ? S_FETCH : S_IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_REQ    = imem_req;
    assign IMEM_ADDR   = pc;
    assign INSTR       = instr;
    assign INSTR_VALID = instr_valid;
    assign PC_OUT      = pc_out;
    assign ERR         = err;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_instr;
    logic [31:0] perf_stall;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_instr <= '0;
            perf_stall <= '0;
        end else begin
            if (instr_valid && INSTR_READY)
                perf_instr <= perf_instr + 32'd1;
            if ((state == S_RESOLVE) || ((state == S_FETCH) && !IMEM_ACK))
                perf_stall <= perf_stall + 32'd1;
        end
    end

    assign PERF_INSTR = perf_instr;
    assign PERF_STALL = perf_stall;
`else
    assign PERF_INSTR = '0;
    assign PERF_STALL = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl (RESET_VEC=0x100, RES_TIMEOUT=4).
// Walks the PC through a hand-planned sequence of straight-line code, taken
// and not-taken branches, a decode stall, the 2^32 wrap, a misaligned target,
// a resolution timeout and a reset that lands mid-fetch.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BR   = 32'h0000_0063;
    localparam logic [31:0] JAL  = 32'h0000_006F;
    localparam logic [31:0] ADDI = 32'h0050_0093;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        EN;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        INSTR_READY;
    logic [31:0] PC_OUT;
    logic        RES_VALID;
    logic        RES_TAKEN;
    logic [31:0] RES_OFFSET;
    logic        ERR;
    logic [31:0] PERF_INSTR;
    logic [31:0] PERF_STALL;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_ctrl #(
        .RESET_VEC   (32'h0000_0100),
        .RES_TIMEOUT (4)
    ) u_dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .EN          (EN),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_READY (INSTR_READY),
        .PC_OUT      (PC_OUT),
        .RES_VALID   (RES_VALID),
        .RES_TAKEN   (RES_TAKEN),
        .RES_OFFSET  (RES_OFFSET),
        .ERR         (ERR),
        .PERF_INSTR  (PERF_INSTR),
        .PERF_STALL  (PERF_STALL)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Wait for a request, ack it one cycle later, and check the capture.
    // Returns on the negedge where INSTR_VALID should first be high.
    task automatic fetch_instr(input logic [31:0] exp_addr, input logic [31:0] data);
        int n = 0;
        while (!IMEM_REQ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("req_seen", {31'b0, IMEM_REQ}, 32'd1);
        chk("imem_addr", IMEM_ADDR, exp_addr);
        @(negedge CLK);
        chk("addr_stable", IMEM_ADDR, exp_addr);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = data;
        @(negedge CLK);
        IMEM_ACK   = 1'b0;
        IMEM_RDATA = 32'hBAD0_BAD0;
        chk("instr_valid", {31'b0, INSTR_VALID}, 32'd1);
        chk("instr", INSTR, data);
        chk("pc_out", PC_OUT, exp_addr);
        chk("req_drop", {31'b0, IMEM_REQ}, 32'd0);
    endtask

    // Called on the capture negedge of a control-flow opcode (INSTR_READY=1).
    task automatic resolve(input int dly, input logic taken, input logic [31:0] off);
        for (int i = 0; i < dly; i++) begin
            @(negedge CLK);
            chk("no_req_resolve", {31'b0, IMEM_REQ}, 32'd0);
            chk("valid_low_resolve", {31'b0, INSTR_VALID}, 32'd0);
        end
        RES_VALID  = 1'b1;
        RES_TAKEN  = taken;
        RES_OFFSET = off;
        @(negedge CLK);
        RES_VALID  = 1'b0;
        RES_TAKEN  = 1'b0;
        RES_OFFSET = 32'h0;
    endtask

    initial begin
        RESET = 1'b0; EN = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = 32'h0;
        INSTR_READY = 1'b1; RES_VALID = 1'b0; RES_TAKEN = 1'b0; RES_OFFSET = 32'h0;
        repeat (2) @(negedge CLK);
        chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_valid", {31'b0, INSTR_VALID}, 32'd0);
        chk("rst_instr", INSTR, 32'h0);
        chk("rst_pc_out", PC_OUT, 32'h100);
        chk("rst_addr", IMEM_ADDR, 32'h100);
        chk("rst_err", {31'b0, ERR}, 32'd0);
        chk("perf_instr", PERF_INSTR, 32'h0);
        chk("perf_stall", PERF_STALL, 32'h0);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_no_en", {31'b0, IMEM_REQ}, 32'd0);
        EN = 1'b1;

        // straight-line code
        fetch_instr(32'h100, NOP);
        fetch_instr(32'h104, NOP);
        fetch_instr(32'h108, NOP);

        // jump to 0x200, taken branch back to 0x1F0, jump to 0x200, not-taken -> 0x204
        fetch_instr(32'h10C, JAL);  resolve(1, 1'b1, 32'h0000_00F4);
        fetch_instr(32'h200, BR);   resolve(3, 1'b1, 32'hFFFF_FFF0);
        fetch_instr(32'h1F0, JAL);  resolve(2, 1'b1, 32'h0000_0010);
        fetch_instr(32'h200, BR);   resolve(3, 1'b0, 32'h1234_5678);

        // decode stalls for 5 cycles
        INSTR_READY = 1'b0;
        fetch_instr(32'h204, ADDI);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_valid", {31'b0, INSTR_VALID}, 32'd1);
            chk("stall_instr", INSTR, ADDI);
            chk("stall_no_req", {31'b0, IMEM_REQ}, 32'd0);
        end
        INSTR_READY = 1'b1;
        @(negedge CLK);
        chk("hs_valid_drop", {31'b0, INSTR_VALID}, 32'd0);

        // jump to top of address space, wrap through +4
        fetch_instr(32'h208, JAL);        resolve(1, 1'b1, 32'hFFFF_FDF4);
        fetch_instr(32'hFFFF_FFFC, NOP);
        fetch_instr(32'h0, JAL);          resolve(1, 1'b1, 32'h0000_0300);

        // misaligned target
        fetch_instr(32'h300, JAL);        resolve(1, 1'b1, 32'h0000_0006);
        chk("misalign_err", {31'b0, ERR}, 32'd1);
        RES_VALID = 1'b1; RES_TAKEN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("err_idle_req", {31'b0, IMEM_REQ}, 32'd0);
        end
        RES_VALID = 1'b0;
        chk("err_sticky", {31'b0, ERR}, 32'd1);
        chk("err_pc_out", PC_OUT, 32'h300);
        chk("err_addr", IMEM_ADDR, 32'h300);

        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_clears_err", {31'b0, ERR}, 32'd0);
        RESET = 1'b1;

        // resolution timeout after 4 RESOLVE cycles
        fetch_instr(32'h100, BR);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("tmo_not_yet", {31'b0, ERR}, 32'd0);
            chk("tmo_no_req", {31'b0, IMEM_REQ}, 32'd0);
        end
        @(negedge CLK);
        chk("tmo_err", {31'b0, ERR}, 32'd1);
        repeat (2) @(negedge CLK);
        chk("tmo_idle_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("tmo_addr", IMEM_ADDR, 32'h100);

        // reset lands mid-fetch with an ack arriving during reset
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        begin
            int n = 0;
            while (!IMEM_REQ && n < 50) begin
                @(negedge CLK);
                n++;
            end
        end
        chk("mid_req_up", {31'b0, IMEM_REQ}, 32'd1);
        RESET = 1'b0;
        IMEM_ACK = 1'b1;
        IMEM_RDATA = 32'hDEAD_BEEF;
        #1;
        chk("mid_rst_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("mid_rst_valid", {31'b0, INSTR_VALID}, 32'd0);
        repeat (2) @(negedge CLK);
        chk("mid_rst_instr", INSTR, 32'h0);
        chk("mid_rst_valid2", {31'b0, INSTR_VALID}, 32'd0);
        IMEM_ACK = 1'b0;
        RESET = 1'b1;
        fetch_instr(32'h100, NOP);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
